// File: rtl/pattern_scan_detector.sv
// Serial pattern detector with saturating hit counter and multiplexed seven-segment bit-history display.
// Optional feature: define PSD_HIT_COUNTER_EN to build the hit counter (otherwise hit_cnt is tied to 0).
module pattern_scan_detector #(
  parameter int         PAT_LEN  = 4,
  parameter logic [7:0] PATTERN  = 8'b0000_1101,
  parameter int         DIGITS   = 4,
  parameter int         SCAN_DIV = 25000,
  parameter int         HIT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              bit_in,
  input  logic              overlap,
  output logic              match,
  output logic [HIT_W-1:0]  hit_cnt,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [PAT_LEN-1:0] TARGET   = PATTERN[PAT_LEN-1:0];

  localparam logic [7:0] GLYPH_ONE   = 8'b1001_1111;
  localparam logic [7:0] GLYPH_ZERO  = 8'b0000_0011;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  logic [PAT_LEN-1:0] hist, hist_next;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [DIGITS-1:0]  disp, disp_next;
  logic [DIGITS-1:0]  dval, dval_next;
  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic               match_cond;

  always_comb begin
    hist_next  = (hist << 1) | PAT_LEN'(bit_in);
    disp_next  = (disp << 1) | DIGITS'(bit_in);
    dval_next  = (dval << 1) | DIGITS'(1'b1);
    match_cond = (fill >= FILL_THR) && (hist_next == TARGET);
    fill_next  = fill;
    // A non-overlapping hit restarts the fill so the next match needs PAT_LEN fresh bits.
    if (match_cond && !overlap)
      fill_next = '0;
    else if (fill < FILL_MAX)
      fill_next = fill + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      disp  <= '0;
      dval  <= '0;
    end else if (step) begin
      hist  <= hist_next;
      fill  <= fill_next;
      match <= match_cond;
      disp  <= disp_next;
      dval  <= dval_next;
    end
  end

`ifdef PSD_HIT_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_cnt <= '0;
    else if (step && match_cond && (hit_cnt != {HIT_W{1'b1}}))
      hit_cnt <= hit_cnt + 1'b1;
  end
`else
  assign hit_cnt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit drivers follow the registered index; segments reflect the live history.
  always_comb begin
    logic [DIGITS-1:0] sel_hot;
    sel_hot      = '0;
    sel_hot[idx] = 1'b1;
    sel          = ~sel_hot;
    seg          = GLYPH_BLANK;
    if (dval[idx])
      seg = disp[idx] ? GLYPH_ONE : GLYPH_ZERO;
  end

endmodule

// File: doc/pattern_scan_detector.md
# pattern_scan_detector

Parametrised serial pattern detector with a multiplexed seven-segment history display and a hit counter. It samples one input bit per qualified step strobe, flags when the last `PAT_LEN` accepted bits equal a programmable pattern, and scans the most recent `DIGITS` bits onto a common-anode display. It sits after the button debouncer, which supplies the one-cycle `step` strobe, and drives the board LED and digit/segment pins directly. It generalises the fixed 4-bit "1101" detector and its 4-digit display with a parametrised pattern, parametrised digit count, selectable overlap mode and hit counting.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits, legal range 2..8.
- `PATTERN`, 8'b0000_1101: target pattern; bits [PAT_LEN-1:0] are used, and bit PAT_LEN-1 is the oldest (first-received) bit.
- `DIGITS`, 4: display digits, legal range 1..8.
- `SCAN_DIV`, 25000: clk cycles each digit stays selected, ≥2.
- `HIT_W`, 8: hit counter width.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `step` input 1: one-cycle strobe; accept `bit_in` on this edge.
- `bit_in` input 1: serial data bit.
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping; sampled with `step`.
- `match` output 1: registered detection flag.
- `hit_cnt` output HIT_W: saturating match count.
- `sel` output DIGITS: active-low one-hot digit select.
- `seg` output 8: active-low segments {a,b,c,d,e,f,g,dp}.

## Operation
- State: `hist[PAT_LEN-1:0]` shift register, `fill` counter 0..PAT_LEN, `disp[DIGITS-1:0]` bit history, `dval[DIGITS-1:0]` valid flags, scan counter, and digit index.
- On `step`:
  - `hist <= {hist[PAT_LEN-2:0], bit_in}`.
  - `fill` increments, saturating at PAT_LEN.
  - Match condition: (fill ≥ PAT_LEN-1 before the update) and the new hist == PATTERN[PAT_LEN-1:0].
  - `match` is set to the match condition. It holds until the next `step`.
  - On a match with `overlap`=0: `fill <= 0`, so the next match needs PAT_LEN fresh bits. On a match with `overlap`=1: `fill` stays saturated.
  - On a match: `hit_cnt` increments and saturates at all-ones (no wrap).
  - `disp <= {disp[DIGITS-2:0], bit_in}` and `dval <= {dval[DIGITS-2:0], 1}`. Display history is independent of overlap mode and match clearing.
- Digit k (sel[k]=0) shows disp[k]; digit 0 is the newest bit.
  - Glyph '1' = 8'b1001_1111.
  - Glyph '0' = 8'b0000_0011.
  - Digit with dval[k]=0 shows blank 8'hFF.
- Scan: the counter counts 0..SCAN_DIV-1. On wrap, the digit index advances k→k+1, and DIGITS-1 wraps to 0. `sel` and `seg` are derived from the registered index; `seg` is combinational from the index and `disp`.

## Timing
- Reset values, all asynchronous:
  - match=0, hit_cnt=0, hist=0, fill=0, disp=0, dval=0.
  - Scan counter=0, index=0, so sel=~1 (digit 0 active) and seg=8'hFF.
- `match`, `hit_cnt` and `disp` update on the clk edge where `step`=1 and are visible in the next cycle. Latency is 1 cycle.
- `step` high for multiple cycles counts as one step per cycle. Consecutive-cycle steps are legal.
- `step` is ignored while `rst`=1. Reset mid-sequence discards partial progress.
- Scan advance and a step on the same edge are independent. The new digit shows the updated `disp`.
- Each digit is active for exactly SCAN_DIV cycles. The full frame is DIGITS×SCAN_DIV cycles.

## Configuration
- `PSD_HIT_COUNTER_EN`:
  - Defined: the hit counter is built as described.
  - Undefined: no counter register exists, `hit_cnt` is tied to 0, and `match` behaviour is unchanged.

## Test plan
- Defaults, overlap=1, steps 1,1,0,1 → match=0,0,0,1 after each step; hit_cnt=1; digits 3..0 show 1,1,0,1.
- overlap=1, steps 1,1,0,1,1,0,1 → match high after steps 4 and 7 only; hit_cnt=2.
- overlap=0, same 7 bits → match high after step 4 only; hit_cnt=1. An 8th step with bit 1 is needed for the next possible match (bits 1,0,1,1 ≠ pattern → still 0).
- Reset: two steps then rst pulse → all outputs return to reset values. After steps 0,1, digits 2..3 show 8'hFF, digit 1 shows 0000_0011 and digit 0 shows 1001_1111.
- SCAN_DIV=4, DIGITS=4 → sel cycles 1110,1101,1011,0111, each held 4 cycles, period 16.
- HIT_W=2, overlap=1, pattern repeated 5 times with overlaps → hit_cnt saturates at 3. Without PSD_HIT_COUNTER_EN, hit_cnt stays 0 while match pulses are unchanged.
